gpout_bank: RTL and testbench

GPOUT_BANK -- requirements
Module: gpout_bank

---
 rtl/gpout_pkg.sv | 15 +
 rtl/gpout_bank_if.sv | 18 +
 rtl/gpout_chan.sv | 105 ++++++++++
 rtl/gpout_bank.sv | 62 ++++++
 tb/tb_gpout_bank.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gpout_pkg.sv
// Shared mode encodings and guard limits for the gpout_bank slice.
// Optional feature macro used elsewhere in the slice: GPOUT_BANK_CLKDIV_EN.
package gpout_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_REG    = 2'b01,
    MODE_STICKY = 2'b10,
    MODE_TOGGLE = 2'b11
  } gpout_mode_e;

  localparam int GUARD_MAX = 15;
  localparam int GUARD_W   = 4;

endpackage

// File: rtl/gpout_bank_if.sv
// Bus bundle between a controller (master) and the gpout_bank (slave).
// Shared by both builds, with and without GPOUT_BANK_CLKDIV_EN.
interface gpout_bank_if #(
  parameter int N_OUT = 6,
  parameter int SEL_W = 6
);
  localparam int N_SRC = 2**SEL_W;

  logic [N_SRC-1:0]       src;
  logic [N_OUT*SEL_W-1:0] sel;
  logic [N_OUT*2-1:0]     mode;
  logic [N_OUT-1:0]       clear;
  logic [N_OUT-1:0]       gpout;
  logic [N_OUT-1:0]       busy;

  modport master (output src, sel, mode, clear, input gpout, busy);
  modport slave  (input src, sel, mode, clear, output gpout, busy);
endinterface

// File: rtl/gpout_chan.sv
// One output channel: source pick, mode logic and select/mode-change guard.
// Independent of GPOUT_BANK_CLKDIV_EN; the bank hands in the effective sources.
module gpout_chan
  import gpout_pkg::*;
#(
  parameter int SEL_W = 6,
  parameter int GUARD = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2**SEL_W-1:0]  src,
  input  logic [SEL_W-1:0]     sel,
  input  logic [1:0]           mode,
  input  logic                 clear,
  output logic                 gpout,
  output logic                 busy
);
  localparam logic [GUARD_W-1:0] GUARD_LD = GUARD_W'(GUARD);
  localparam logic [GUARD_W-1:0] CNT_ZERO = {GUARD_W{1'b0}};
  localparam logic [GUARD_W-1:0] CNT_ONE  = {{(GUARD_W-1){1'b0}}, 1'b1};

  logic [SEL_W-1:0]   sel_q;
  gpout_mode_e        mode_q;
  logic [GUARD_W-1:0] guard_cnt;
  logic               state_r;
  logic               hold_q;
  logic               prev_r;
  logic               reg_r;
  logic               pick_s;
  logic               change_s;
  logic               guarding_s;
  logic               live_s;
  logic               state_nx_s;

  assign pick_s     = src[sel_q];
  assign change_s   = (sel != sel_q) || (mode != mode_q);
  assign guarding_s = (guard_cnt != CNT_ZERO);

  // Value the channel would deliver with no guard active.
  always_comb begin
    live_s = 1'b0;
    case (mode_q)
      MODE_DIRECT: live_s = pick_s;
      MODE_REG:    live_s = reg_r;
      MODE_STICKY: live_s = state_r;
      MODE_TOGGLE: live_s = state_r;
      default:     live_s = 1'b0;
    endcase
  end

  // Sticky/toggle next state; clear dominates any coincident set or edge.
  always_comb begin
    state_nx_s = 1'b0;
    case (mode_q)
      MODE_STICKY: state_nx_s = (state_r | pick_s) & ~clear;
      MODE_TOGGLE: state_nx_s = clear ? 1'b0 : (state_r ^ (pick_s & ~prev_r));
      default:     state_nx_s = 1'b0;
    endcase
  end

  // Output mux: quiet in reset, held value while guarding.
  always_comb begin
    if (reset) begin
      gpout = 1'b0;
      busy  = 1'b0;
    end else if (guarding_s) begin
      gpout = hold_q;
      busy  = 1'b1;
    end else begin
      gpout = live_s;
      busy  = 1'b0;
    end
  end

  // Channel state. prev_r samples every edge, so the last guard cycle
  // reloads it from the new source and guard exit sees no false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q     <= sel;
      mode_q    <= gpout_mode_e'(mode);
      guard_cnt <= CNT_ZERO;
      state_r   <= 1'b0;
      hold_q    <= 1'b0;
      prev_r    <= 1'b0;
      reg_r     <= 1'b0;
    end else begin
      sel_q  <= sel;
      mode_q <= gpout_mode_e'(mode);
      prev_r <= pick_s;
      reg_r  <= pick_s;
      if (!guarding_s) begin
        hold_q <= gpout;
      end
      if (change_s) begin
        guard_cnt <= GUARD_LD;
        state_r   <= 1'b0;
      end else if (guarding_s) begin
        guard_cnt <= guard_cnt - CNT_ONE;
      end else begin
        state_r <= state_nx_s;
      end
    end
  end

endmodule

// File: rtl/gpout_bank.sv
// Bank of N_OUT independent general-purpose output channels.
// GPOUT_BANK_CLKDIV_EN replaces the top DIV_W source indices with divided clocks.
module gpout_bank
  import gpout_pkg::*;
#(
  parameter int N_OUT = 6,
  parameter int SEL_W = 6,
  parameter int GUARD = 2,
  parameter int DIV_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  gpout_bank_if.slave  bus
);
  localparam int N_SRC     = 2**SEL_W;
  localparam int GUARD_EFF = (GUARD > GUARD_MAX) ? GUARD_MAX : GUARD;

  logic [N_SRC-1:0] src_eff_s;
  logic [N_OUT-1:0] gpout_s;
  logic [N_OUT-1:0] busy_s;

`ifdef GPOUT_BANK_CLKDIV_EN
  logic [DIV_W-1:0] div_r;

  // Free-running divider; bit k toggles at clk/2^(k+1).
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Divider bits take over the top source indices.
  always_comb begin
    src_eff_s = bus.src;
    src_eff_s[N_SRC-1 -: DIV_W] = div_r;
  end
`else
  assign src_eff_s = {bus.src[N_SRC-1 -: DIV_W], bus.src[N_SRC-DIV_W-1:0]};
`endif

  for (genvar c = 0; c < N_OUT; c++) begin : g_chan
    gpout_chan #(
      .SEL_W (SEL_W),
      .GUARD (GUARD_EFF)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .src   (src_eff_s),
      .sel   (bus.sel[c*SEL_W +: SEL_W]),
      .mode  (bus.mode[c*2 +: 2]),
      .clear (bus.clear[c]),
      .gpout (gpout_s[c]),
      .busy  (busy_s[c])
    );
  end

  assign bus.gpout = gpout_s;
  assign bus.busy  = busy_s;

endmodule

// File: tb/tb_gpout_bank.sv
// Directed scoreboard bench for gpout_bank: three banks with GUARD 2, 3 and 0
// share one stimulus; GPOUT_BANK_CLKDIV_EN selects the divider checks.
module tb_gpout_bank;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gpout_bank_if #(.N_OUT(6), .SEL_W(6)) bus2 ();
  gpout_bank_if #(.N_OUT(6), .SEL_W(6)) bus3 ();
  gpout_bank_if #(.N_OUT(6), .SEL_W(6)) bus0 ();

  assign bus3.src = bus2.src;   assign bus0.src = bus2.src;
  assign bus3.sel = bus2.sel;   assign bus0.sel = bus2.sel;
  assign bus3.mode = bus2.mode; assign bus0.mode = bus2.mode;
  assign bus3.clear = bus2.clear; assign bus0.clear = bus2.clear;

  gpout_bank #(.N_OUT(6), .SEL_W(6), .GUARD(2), .DIV_W(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  gpout_bank #(.N_OUT(6), .SEL_W(6), .GUARD(3), .DIV_W(4)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
  gpout_bank #(.N_OUT(6), .SEL_W(6), .GUARD(0), .DIV_W(4)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  typedef struct {
    string tag;
    int    dut;
    int    ch;
    logic  gp;
    logic  bz;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

`ifdef GPOUT_BANK_CLKDIV_EN
  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end
`endif

  function automatic logic obs_gp(input int dut, input int ch);
    case (dut)
      0:       return bus0.gpout[ch];
      2:       return bus2.gpout[ch];
      3:       return bus3.gpout[ch];
      default: return 1'bx;
    endcase
  endfunction

  function automatic logic obs_bz(input int dut, input int ch);
    case (dut)
      0:       return bus0.busy[ch];
      2:       return bus2.busy[ch];
      3:       return bus3.busy[ch];
      default: return 1'bx;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int dut, input int ch, input logic gp, input logic bz);
    exp_t e;
    e.tag = tag; e.dut = dut; e.ch = ch; e.gp = gp; e.bz = bz;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic og;
    logic ob;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      og = obs_gp(e.dut, e.ch);
      ob = obs_bz(e.dut, e.ch);
      checks++;
      assert (og === e.gp) else begin
        failures++;
        $error("FAIL %s gpout dut%0d ch%0d observed=%b expected=%b", e.tag, e.dut, e.ch, og, e.gp);
      end
      checks++;
      assert (ob === e.bz) else begin
        failures++;
        $error("FAIL %s busy dut%0d ch%0d observed=%b expected=%b", e.tag, e.dut, e.ch, ob, e.bz);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_now();
    #1;
    check_all();
  endtask

  task automatic set_sel(input int c, input logic [5:0] v);
    bus2.sel[c*6 +: 6] = v;
  endtask

  task automatic set_mode(input int c, input logic [1:0] m);
    bus2.mode[c*2 +: 2] = m;
  endtask

  initial begin
    reset = 1'b1;
    bus2.src = 64'd0;
    bus2.sel = 36'd0;
    bus2.mode = 12'd0;
    bus2.clear = 6'd0;
    set_sel(0, 6'd5);
    bus2.src[5] = 1'b1;
    tick_n(2);

    // Held in reset: outputs quiet even with a live direct source.
    push_exp("reset_g2", 2, 0, 1'b0, 1'b0);
    push_exp("reset_g3", 3, 0, 1'b0, 1'b0);
    check_now();

    // Release: direct source visible on the first cycle, no guard.
    reset = 1'b0;
    push_exp("release", 2, 0, 1'b1, 1'b0);
    push_exp("release_g0", 0, 0, 1'b1, 1'b0);
    tick();
    check_all();

    // Select 5 -> 9 with src[9]=0: hold 1 while guarding.
    set_sel(0, 6'd9);
    push_exp("guard_e0", 2, 0, 1'b1, 1'b1);
    push_exp("guard_e0_g3", 3, 0, 1'b1, 1'b1);
    push_exp("guard_e0_g0", 0, 0, 1'b0, 1'b0);
    tick(); check_all();
    push_exp("guard_e1", 2, 0, 1'b1, 1'b1);
    push_exp("guard_e1_g3", 3, 0, 1'b1, 1'b1);
    push_exp("guard_e1_g0", 0, 0, 1'b0, 1'b0);
    tick(); check_all();
    push_exp("guard_exit", 2, 0, 1'b0, 1'b0);
    push_exp("guard_e2_g3", 3, 0, 1'b1, 1'b1);
    tick(); check_all();
    push_exp("guard_exit_g3", 3, 0, 1'b0, 1'b0);
    tick(); check_all();

    // Restart: 9 -> 11, then 11 -> 12 one cycle later; src[12]=1.
    bus2.src[12] = 1'b1;
    set_sel(0, 6'd11);
    push_exp("rst1_g3", 3, 0, 1'b0, 1'b1);
    push_exp("rst1_g0", 0, 0, 1'b0, 1'b0);
    tick(); check_all();
    set_sel(0, 6'd12);
    push_exp("rst2_g3", 3, 0, 1'b0, 1'b1);
    push_exp("rst2_g2", 2, 0, 1'b0, 1'b1);
    push_exp("rst2_g0", 0, 0, 1'b1, 1'b0);
    tick(); check_all();
    push_exp("rst3_g3", 3, 0, 1'b0, 1'b1);
    push_exp("rst3_g2", 2, 0, 1'b0, 1'b1);
    tick(); check_all();
    push_exp("rst4_g3", 3, 0, 1'b0, 1'b1);
    push_exp("rst4_g2", 2, 0, 1'b1, 1'b0);
    tick(); check_all();
    push_exp("rst5_g3", 3, 0, 1'b1, 1'b0);
    tick(); check_all();

    // Sticky on ch1; ch0 must be untouched by the ch1 change.
    set_sel(1, 6'd3);
    set_mode(1, 2'b10);
    push_exp("indep_ch0", 2, 0, 1'b1, 1'b0);
    push_exp("sticky_guard", 2, 1, 1'b0, 1'b1);
    tick(); check_all();
    tick_n(3);
    push_exp("sticky_idle", 2, 1, 1'b0, 1'b0);
    check_now();
    bus2.src[3] = 1'b1;
    push_exp("sticky_set", 2, 1, 1'b1, 1'b0);
    tick(); check_all();
    bus2.src[3] = 1'b0;
    push_exp("sticky_hold", 2, 1, 1'b1, 1'b0);
    tick(); check_all();
    bus2.src[3] = 1'b1;
    bus2.clear[1] = 1'b1;
    push_exp("sticky_clr_wins", 2, 1, 1'b0, 1'b0);
    tick(); check_all();
    bus2.clear[1] = 1'b0;
    push_exp("sticky_reset", 2, 1, 1'b1, 1'b0);
    tick(); check_all();
    bus2.src[3] = 1'b0;

    // Toggle on ch2: pattern 0,1,1,0,1 gives two toggles.
    set_sel(2, 6'd7);
    set_mode(2, 2'b11);
    tick_n(4);
    push_exp("tog_idle", 2, 2, 1'b0, 1'b0);
    check_now();
    bus2.src[7] = 1'b0; push_exp("tog_p0", 2, 2, 1'b0, 1'b0); tick(); check_all();
    bus2.src[7] = 1'b1; push_exp("tog_p1", 2, 2, 1'b1, 1'b0); tick(); check_all();
    bus2.src[7] = 1'b1; push_exp("tog_p2", 2, 2, 1'b1, 1'b0); tick(); check_all();
    bus2.src[7] = 1'b0; push_exp("tog_p3", 2, 2, 1'b1, 1'b0); tick(); check_all();
    bus2.src[7] = 1'b1; push_exp("tog_p4", 2, 2, 1'b0, 1'b0); tick(); check_all();

    // Reselect to a source already high: no toggle at guard exit.
    bus2.src[8] = 1'b1;
    set_sel(2, 6'd8);
    push_exp("tog_sw_g0", 2, 2, 1'b0, 1'b1); tick(); check_all();
    push_exp("tog_sw_g1", 2, 2, 1'b0, 1'b1); tick(); check_all();
    push_exp("tog_sw_exit", 2, 2, 1'b0, 1'b0); tick(); check_all();
    push_exp("tog_sw_after", 2, 2, 1'b0, 1'b0); tick(); check_all();
    bus2.src[8] = 1'b0; push_exp("tog_sw_low", 2, 2, 1'b0, 1'b0); tick(); check_all();
    bus2.src[8] = 1'b1; push_exp("tog_sw_rise", 2, 2, 1'b1, 1'b0); tick(); check_all();
    bus2.src[8] = 1'b0; tick();
    bus2.src[8] = 1'b1;
    bus2.clear[2] = 1'b1;
    push_exp("tog_clr_wins", 2, 2, 1'b0, 1'b0); tick(); check_all();
    bus2.clear[2] = 1'b0;

    // Direct mode is zero latency; registered mode lags one cycle.
    set_sel(3, 6'd4);
    set_mode(3, 2'b01);
    tick_n(4);
    bus2.src[12] = 1'b0;
    bus2.src[4] = 1'b1;
    push_exp("direct_zero_lat", 2, 0, 1'b0, 1'b0);
    push_exp("reg_before_edge", 2, 3, 1'b0, 1'b0);
    check_now();
    push_exp("reg_after_edge", 2, 3, 1'b1, 1'b0);
    tick(); check_all();

    // Top source indices: divided clocks or plain src.
    set_sel(4, 6'd60);
    set_sel(5, 6'd63);
    tick_n(4);
`ifdef GPOUT_BANK_CLKDIV_EN
    for (int i = 0; i < 16; i++) begin
      push_exp("div_sel60", 2, 4, cyc[0], 1'b0);
      push_exp("div_sel63", 2, 5, cyc[3], 1'b0);
      check_now();
      tick();
    end
`else
    bus2.src[60] = 1'b1;
    push_exp("src60_high", 2, 4, 1'b1, 1'b0);
    push_exp("src63_low", 2, 5, 1'b0, 1'b0);
    check_now();
    bus2.src[60] = 1'b0;
    bus2.src[63] = 1'b1;
    push_exp("src60_low", 2, 4, 1'b0, 1'b0);
    push_exp("src63_high", 2, 5, 1'b1, 1'b0);
    check_now();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
